mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between instruction fetch (I-side) and load/store (D-side) for the RISC-V core.
- Registers the winning request and drives it to memory until the memory's `m_ready`.
- Returns read data with a one-cycle ack pulse and raises a core stall while any request is pending.
- A watchdog aborts accesses the memory never completes.

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_wdog.sv | 26 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the I/D memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam logic [31:0] RDATA_ABORT = 32'd0;

endpackage

// File: rtl/mem_arb_wdog.sv
// rtl/mem_arb_wdog.sv - per-access wait counter; flags the last cycle a granted access may wait
module mem_arb_wdog #(
    parameter int MAX_WAIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_timeout = (r_cnt == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store; ARB_RR_EN selects round-robin ties
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_req,
    output logic              m_wen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall,
    output logic              err
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    arb_state_t        w_tie;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic              r_i_ack;
    logic              r_d_ack;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;
    logic              w_i_req;
    logic              w_d_req;
    logic              w_busy;
    logic              w_done;
    logic              w_abort;
    logic              w_load;
    logic              w_timeout;

    // A side's request is ignored in its own ack cycle so a held req is not granted twice.
    assign w_i_req = i_req & ~r_i_ack;
    assign w_d_req = d_req & ~r_d_ack;

    assign w_busy  = (r_state != IDLE);
    assign w_done  = w_busy & m_ready;
    assign w_abort = w_busy & ~m_ready & w_timeout;
    assign w_load  = (w_next != IDLE) & ((r_state == IDLE) | w_done);

`ifdef ARB_RR_EN
    grant_t r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= GNT_I;
        end else if (w_done) begin
            r_last <= (r_state == BUSY_D) ? GNT_D : GNT_I;
        end
    end

    assign w_tie = (r_last == GNT_D) ? BUSY_I : BUSY_D;
`else
    assign w_tie = BUSY_D;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) w_next = w_tie;
                else if (w_d_req)       w_next = BUSY_D;
                else if (w_i_req)       w_next = BUSY_I;
            end
            BUSY_I: begin
                if (m_ready)        w_next = w_d_req ? BUSY_D : IDLE;
                else if (w_timeout) w_next = IDLE;
            end
            BUSY_D: begin
                if (m_ready)        w_next = w_i_req ? BUSY_I : IDLE;
                else if (w_timeout) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                if (w_next == BUSY_D) begin
                    r_addr  <= d_addr;
                    r_wen   <= d_wen;
                    r_wdata <= d_wdata;
                end else begin
                    r_addr  <= i_addr;
                    r_wen   <= 1'b0;
                    r_wdata <= '0;
                end
            end
            r_i_ack <= (r_state == BUSY_I) & (m_ready | w_timeout);
            r_d_ack <= (r_state == BUSY_D) & (m_ready | w_timeout);
            if ((r_state == BUSY_I) && (m_ready || w_timeout)) begin
                r_i_rdata <= m_ready ? m_rdata : DATA_W'(RDATA_ABORT);
            end
            // Stores and aborted loads both return the abort value.
            if ((r_state == BUSY_D) && (m_ready || w_timeout)) begin
                r_d_rdata <= (m_ready && !r_wen) ? m_rdata : DATA_W'(RDATA_ABORT);
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    mem_arb_wdog #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_load),
        .i_en      (w_busy & ~m_ready),
        .o_timeout (w_timeout)
    );

    assign m_req   = w_busy;
    assign m_wen   = r_wen;
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign err     = r_err;
    assign stall   = (i_req & ~r_i_ack) | (d_req & ~r_d_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter with MAX_WAIT = 8
module tb_mem_port_arbiter;

    localparam int MW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req = 1'b0;
    logic        d_wen = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata = '0;
    logic        m_ready = 1'b0;
    logic        stall;
    logic        err;

    int total = 0;
    int bad = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req got=%b exp=0", m_req); end
        total++; if ({i_ack, d_ack, err} !== 3'b000) begin bad++; $display("FAIL rst_acks_err got=%b exp=000", {i_ack, d_ack, err}); end
        total++; if ({i_rdata, d_rdata} !== 64'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", {i_rdata, d_rdata}); end
        total++; if ({m_wen, m_addr} !== 33'd0) begin bad++; $display("FAIL rst_mbus got=%h exp=0", {m_wen, m_addr}); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    endtask

    task automatic test_i_read();
        int stall_cnt;
        stall_cnt = 0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h100;
        #1; if (stall === 1'b1) stall_cnt++;
        @(negedge clk);
        total++; if ({m_req, m_wen, m_addr} !== {2'b10, 32'h100}) begin bad++; $display("FAIL iread_bus got=%b/%b/%h exp=1/0/100", m_req, m_wen, m_addr); end
        total++; if (i_ack !== 1'b0) begin bad++; $display("FAIL iread_early_ack got=%b exp=0", i_ack); end
        m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
        #1; if (stall === 1'b1) stall_cnt++;
        @(negedge clk);
        m_ready = 1'b0;
        total++; if ({i_ack, m_req} !== 2'b10) begin bad++; $display("FAIL iread_ack got=%b exp=10", {i_ack, m_req}); end
        total++; if (i_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL iread_data got=%h exp=deadbeef", i_rdata); end
        #1; if (stall === 1'b1) stall_cnt++;
        i_req = 1'b0;
        total++; if (stall_cnt !== 2) begin bad++; $display("FAIL iread_stall_cycles got=%0d exp=2", stall_cnt); end
        @(negedge clk);
        total++; if ({i_ack, m_req} !== 2'b00) begin bad++; $display("FAIL iread_after got=%b exp=00", {i_ack, m_req}); end
    endtask

    task automatic test_d_store();
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if ({m_req, m_wen, m_addr, m_wdata, d_ack} !== {2'b11, 32'h40, 32'h12345678, 1'b0}) begin
                bad++; $display("FAIL dstore_bus_c%0d got=%b/%b/%h/%h ack=%b exp=1/1/40/12345678 ack=0", k, m_req, m_wen, m_addr, m_wdata, d_ack);
            end
            if (k == 4) begin m_ready = 1'b1; m_rdata = 32'hAAAA5555; end
        end
        @(negedge clk);
        m_ready = 1'b0;
        total++; if ({d_ack, m_req} !== 2'b10) begin bad++; $display("FAIL dstore_ack got=%b exp=10", {d_ack, m_req}); end
        total++; if (d_rdata !== 32'd0) begin bad++; $display("FAIL dstore_rdata got=%h exp=0", d_rdata); end
        d_req = 1'b0; d_wen = 1'b0;
        @(negedge clk);
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL dstore_ack_width got=%b exp=0", d_ack); end
    endtask

    task automatic test_contention();
        logic [5:0] exp_req;
        logic [5:0] exp_dack;
        logic [5:0] exp_iack;
        exp_req  = 6'b011011;
        exp_dack = 6'b010010;
        exp_iack = 6'b100100;
        do_reset();
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h300;
        m_ready = 1'b1; m_rdata = 32'h11110000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if ({m_req, d_ack, i_ack} !== {exp_req[k], exp_dack[k], exp_iack[k]}) begin
                bad++; $display("FAIL contend_c%0d got=%b%b%b exp=%b%b%b", k + 1, m_req, d_ack, i_ack, exp_req[k], exp_dack[k], exp_iack[k]);
            end
            if (exp_req[k]) begin
                total++;
                if (m_addr !== ((k % 3 == 0) ? 32'h300 : 32'h200)) begin
                    bad++; $display("FAIL contend_addr_c%0d got=%h exp=%h", k + 1, m_addr, (k % 3 == 0) ? 32'h300 : 32'h200);
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h104; m_ready = 1'b0;
        for (int k = 1; k <= MW; k++) begin
            @(negedge clk);
            total++; if ({m_req, i_ack, err} !== 3'b100) begin bad++; $display("FAIL wdog_wait_c%0d got=%b exp=100", k, {m_req, i_ack, err}); end
        end
        @(negedge clk);
        total++; if ({i_ack, err, m_req} !== 3'b110) begin bad++; $display("FAIL wdog_abort got=%b exp=110", {i_ack, err, m_req}); end
        total++; if (i_rdata !== 32'd0) begin bad++; $display("FAIL wdog_rdata got=%h exp=0", i_rdata); end
        i_req = 1'b0;
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        m_ready = 1'b1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        m_ready = 1'b0;
        total++; if ({d_ack, err} !== 2'b11) begin bad++; $display("FAIL wdog_sticky got=%b exp=11", {d_ack, err}); end
        total++; if (d_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL wdog_next_rdata got=%h exp=cafef00d", d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h80;
        for (int k = 1; k <= 6; k++) @(negedge clk);
        total++; if (m_req !== 1'b1) begin bad++; $display("FAIL rmid_busy got=%b exp=1", m_req); end
        rst = 1'b1; m_ready = 1'b1; m_rdata = 32'h77777777;
        @(negedge clk);
        total++; if ({m_req, d_ack, err} !== 3'b000) begin bad++; $display("FAIL rmid_after got=%b exp=000", {m_req, d_ack, err}); end
        rst = 1'b0; m_ready = 1'b0;
        @(negedge clk);
        total++; if ({m_req, m_addr} !== {1'b1, 32'h80}) begin bad++; $display("FAIL rmid_regrant got=%b/%h exp=1/80", m_req, m_addr); end
        m_ready = 1'b1; m_rdata = 32'h5A5A1234;
        @(negedge clk);
        m_ready = 1'b0;
        total++; if ({d_ack, d_rdata} !== {1'b1, 32'h5A5A1234}) begin bad++; $display("FAIL rmid_done got=%b/%h exp=1/5a5a1234", d_ack, d_rdata); end
        d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_held_req();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h108;
        @(negedge clk);
        m_ready = 1'b1; m_rdata = 32'h01020304;
        @(negedge clk);
        m_ready = 1'b0;
        total++; if ({i_ack, m_req} !== 2'b10) begin bad++; $display("FAIL held_ack got=%b exp=10", {i_ack, m_req}); end
        @(negedge clk);
        total++; if ({i_ack, m_req} !== 2'b00) begin bad++; $display("FAIL held_no_dup got=%b exp=00", {i_ack, m_req}); end
        @(negedge clk);
        total++; if ({m_req, m_addr} !== {1'b1, 32'h108}) begin bad++; $display("FAIL held_new_access got=%b/%h exp=1/108", m_req, m_addr); end
        m_ready = 1'b1; m_rdata = 32'h0A0B0C0D;
        @(negedge clk);
        m_ready = 1'b0; i_req = 1'b0;
        total++; if ({i_ack, i_rdata} !== {1'b1, 32'h0A0B0C0D}) begin bad++; $display("FAIL held_second got=%b/%h exp=1/0a0b0c0d", i_ack, i_rdata); end
        @(negedge clk);
    endtask

    // Random traffic against a transaction-level model: memory array, pending requests, grant rules.
    logic [31:0] mem_m [0:127];

    task automatic test_random();
        bit ip, dp, el_i, el_d, in_acc, xi, xd, err_x, acc_wen;
        int kind, acc_side, busy_cnt, lat, last_g, exp_g, idx;
        logic [31:0] xi_d, xd_d, acc_addr, acc_wdata, ea;
        logic ew;
        do_reset();
        for (int k = 0; k < 128; k++) mem_m[k] = $urandom;
        ip = 0; dp = 0; el_i = 0; el_d = 0; in_acc = 0; xi = 0; xd = 0; err_x = 0;
        kind = 0; acc_side = 0; busy_cnt = 0; lat = 0; last_g = 0; acc_wen = 0;
        xi_d = '0; xd_d = '0; acc_addr = '0; acc_wdata = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            total++; if (i_ack !== xi) begin bad++; $display("FAIL rnd_i_ack n=%0d got=%b exp=%b", n, i_ack, xi); end
            if (xi) begin total++; if (i_rdata !== xi_d) begin bad++; $display("FAIL rnd_i_rdata n=%0d got=%h exp=%h", n, i_rdata, xi_d); end end
            total++; if (d_ack !== xd) begin bad++; $display("FAIL rnd_d_ack n=%0d got=%b exp=%b", n, d_ack, xd); end
            if (xd) begin total++; if (d_rdata !== xd_d) begin bad++; $display("FAIL rnd_d_rdata n=%0d got=%h exp=%h", n, d_rdata, xd_d); end end
            total++; if (err !== err_x) begin bad++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, err, err_x); end
            if (kind == 1) begin
                total++;
                if (m_req !== 1'b1 || m_addr !== acc_addr || m_wen !== acc_wen) begin
                    bad++; in_acc = 0;
                    $display("FAIL rnd_hold n=%0d got=%b/%h/%b exp=1/%h/%b", n, m_req, m_addr, m_wen, acc_addr, acc_wen);
                end
            end else begin
                exp_g = -1;
                if (kind == 2) begin
                    if (acc_side == 0 && el_d) exp_g = 1;
                    else if (acc_side == 1 && el_i) exp_g = 0;
                end else if (kind == 0) begin
`ifdef ARB_RR_EN
                    if (el_i && el_d) exp_g = (last_g == 1) ? 0 : 1;
`else
                    if (el_i && el_d) exp_g = 1;
`endif
                    else if (el_d) exp_g = 1;
                    else if (el_i) exp_g = 0;
                end
                total++;
                if (exp_g < 0) begin
                    if (m_req !== 1'b0) begin bad++; $display("FAIL rnd_no_grant n=%0d got=%b exp=0", n, m_req); end
                end else begin
                    ea = (exp_g == 1) ? d_addr : i_addr;
                    ew = (exp_g == 1) ? d_wen : 1'b0;
                    if (m_req !== 1'b1 || m_addr !== ea || m_wen !== ew || (ew && m_wdata !== d_wdata)) begin
                        bad++; $display("FAIL rnd_grant n=%0d got=%b/%h/%b exp=1/%h/%b", n, m_req, m_addr, m_wen, ea, ew);
                    end
                    in_acc = 1; acc_side = exp_g; acc_addr = ea; acc_wen = ew; acc_wdata = d_wdata; busy_cnt = 0;
                    lat = ($urandom_range(0, 11) == 0) ? 99 : int'($urandom_range(0, 3));
                end
            end
            if (i_ack) ip = 0;
            if (d_ack) dp = 0;
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip = 1; i_addr = {23'd0, 1'b0, 6'($urandom), 2'b00};
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp = 1; d_addr = {23'd0, 1'b1, 6'($urandom), 2'b00};
                d_wen = 1'($urandom); d_wdata = $urandom;
            end
            i_req = ip; d_req = dp;
            el_i = i_req && !i_ack;
            el_d = d_req && !d_ack;
            xi = 0; xd = 0; kind = 0; m_ready = 1'b0; m_rdata = $urandom;
            if (in_acc) begin
                idx = int'({acc_addr[8], acc_addr[7:2]});
                if (busy_cnt == lat) begin
                    m_ready = 1'b1;
                    if (acc_wen) begin mem_m[idx] = acc_wdata; ea = '0; end
                    else begin m_rdata = mem_m[idx]; ea = m_rdata; end
                    if (acc_side == 0) begin xi = 1; xi_d = ea; end else begin xd = 1; xd_d = ea; end
                    kind = 2; in_acc = 0; last_g = acc_side;
                end else if (busy_cnt == MW - 1) begin
                    if (acc_side == 0) begin xi = 1; xi_d = '0; end else begin xd = 1; xd_d = '0; end
                    err_x = 1; kind = 3; in_acc = 0;
                end else begin
                    kind = 1; busy_cnt++;
                end
            end else begin
                m_ready = 1'($urandom);
            end
            #1;
            total++;
            if (stall !== ((i_req & ~i_ack) | (d_req & ~d_ack))) begin
                bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall, (i_req & ~i_ack) | (d_req & ~d_ack));
            end
        end
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_d_store();
        test_contention();
        test_watchdog();
        test_reset_mid();
        test_held_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
